// File: rtl/conv_mc_mmio_engine_pkg.sv
// ---------------------------------------------------------------------------
// conv_mc_pkg
// Shared definitions for the multi-channel memory-mapped convolution engine:
//   - word-address bases of the kernel, input and output regions
//   - addresses of the CFG / CH_MASK / START / STATUS registers
//   - STATUS bit positions
//   - sequencer state encoding
//   - size helpers (elements per word, words per region, accumulator width)
// ---------------------------------------------------------------------------
package conv_mc_pkg;

   localparam int KBASE       = 'h0000;
   localparam int IBASE       = 'h0400;
   localparam int OBASE       = 'h1000;
   localparam int CFG_ADDR    = 'h3FFC;
   localparam int MASK_ADDR   = 'h3FFD;
   localparam int START_ADDR  = 'h3FFE;
   localparam int STATUS_ADDR = 'h3FFF;

   localparam int ST_DONE    = 0;
   localparam int ST_BUSY    = 1;
   localparam int ST_CFG_ERR = 2;
   localparam int ST_RELU    = 3;

   typedef enum logic [2:0] {IDLE, CHECK, MAC, WB, DONE} state_e;

   // Elements packed into one bus word.
   function automatic int f_epw(input int p, input int dw);
      return dw / p;
   endfunction

   // Kernel words per channel, rounded up.
   function automatic int f_kw(input int k, input int epw);
      return (k + epw - 1) / epw;
   endfunction

   // Input words per channel.
   function automatic int f_iw(input int max_len, input int epw);
      return max_len / epw;
   endfunction

   // Sum of K products of two P-bit signed values cannot overflow this width.
   function automatic int f_acc_width(input int p, input int k);
      return 2 * p + $clog2(k);
   endfunction

   // Index width for an n-entry array, never narrower than one bit.
   function automatic int f_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_mc_mmio_engine_if.sv
// ---------------------------------------------------------------------------
// conv_mc_mmio_engine_if
// Host bus of the convolution engine.
//   i_we / i_write_addr / i_data : word write port
//   i_re / i_read_addr / o_data  : word read port, 1-cycle registered latency
//   o_busy                       : run in progress
//   o_done                       : sticky completion flag
// master = host side, slave = engine side.
// ---------------------------------------------------------------------------
interface conv_mc_mmio_engine_if #(
   parameter int DATA_WIDTH       = 32,
   parameter int VALID_ADDR_WIDTH = 14
);
   logic                        i_we;
   logic                        i_re;
   logic [VALID_ADDR_WIDTH-1:0] i_write_addr;
   logic [VALID_ADDR_WIDTH-1:0] i_read_addr;
   logic [DATA_WIDTH-1:0]       i_data;
   logic [DATA_WIDTH-1:0]       o_data;
   logic                        o_busy;
   logic                        o_done;

   modport master (
      output i_we, i_re, i_write_addr, i_read_addr, i_data,
      input  o_data, o_busy, o_done
   );

   modport slave (
      input  i_we, i_re, i_write_addr, i_read_addr, i_data,
      output o_data, o_busy, o_done
   );
endinterface

// File: rtl/conv_mc_mmio_engine_mac_lane.sv
// ---------------------------------------------------------------------------
// conv_mac_lane
// Signed P x P multiply-accumulate with a synchronous clear.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_en         : accumulate this cycle
//   i_clr        : with i_en, start a fresh sum (acc = a*b instead of acc + a*b)
//   i_a, i_b     : signed operands
//   o_acc        : registered signed accumulator
// ---------------------------------------------------------------------------
module conv_mac_lane
   import conv_mc_pkg::*;
#(
   parameter int P         = 4,
   parameter int ACC_WIDTH = 12
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic                        i_clr,
   input  logic signed [P-1:0]         i_a,
   input  logic signed [P-1:0]         i_b,
   output logic signed [ACC_WIDTH-1:0] o_acc
);

   logic signed [2*P-1:0]       prod;
   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

   always_comb begin
      prod  = i_a * i_b;
      base  = i_clr ? '0 : acc_q;
      acc_d = acc_q;
      if (i_en) acc_d = base + ACC_WIDTH'(prod);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign o_acc = acc_q;

endmodule

// File: rtl/conv_mc_mmio_engine.sv
// ---------------------------------------------------------------------------
// conv_mc_mmio_engine
// Memory-mapped multi-channel 1-D convolution engine. The host loads packed
// signed kernels and inputs, sets the input length (CFG) and channel mask,
// then writes START. One MAC per cycle is run over every enabled channel and
// each result is written back as one sign-extended word.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : write port, registered read port, o_busy, o_done
// Build option:
//   CONV_RELU_EN : results are clamped at zero before write-back and STATUS
//                  bit3 reads 1.
// ---------------------------------------------------------------------------
module conv_mc_mmio_engine
   import conv_mc_pkg::*;
#(
   parameter int PRECISION_WIDTH  = 4,
   parameter int DATA_WIDTH       = 32,
   parameter int VALID_ADDR_WIDTH = 14,
   parameter int KERNEL_LEN       = 9,
   parameter int MAX_INPUT_LEN    = 64,
   parameter int CHANNELS         = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   conv_mc_mmio_engine_if.slave bus
);

   localparam int P     = PRECISION_WIDTH;
   localparam int EPW   = f_epw(P, DATA_WIDTH);
   localparam int KW    = f_kw(KERNEL_LEN, EPW);
   localparam int IW    = f_iw(MAX_INPUT_LEN, EPW);
   localparam int ACC_W = f_acc_width(P, KERNEL_LEN);
   localparam int NK    = CHANNELS * KW;
   localparam int NI    = CHANNELS * IW;
   localparam int NO    = CHANNELS * MAX_INPUT_LEN;
   localparam int KIW   = f_idx_w(NK);
   localparam int IIW   = f_idx_w(NI);
   localparam int OIW   = f_idx_w(NO);
   localparam logic [15:0] K16    = 16'(KERNEL_LEN);
   localparam logic [15:0] MAXN16 = 16'(MAX_INPUT_LEN);
`ifdef CONV_RELU_EN
   localparam logic RELU_EN = 1'b1;
`else
   localparam logic RELU_EN = 1'b0;
`endif

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   kern_q [NK];
   logic [DATA_WIDTH-1:0]   kern_d [NK];
   logic [DATA_WIDTH-1:0]   inp_q  [NI];
   logic [DATA_WIDTH-1:0]   inp_d  [NI];
   logic [DATA_WIDTH-1:0]   out_q  [NO];
   logic [DATA_WIDTH-1:0]   out_d  [NO];
   logic [15:0]             cfg_q, cfg_d;
   logic [CHANNELS-1:0]     mask_q, mask_d;
   logic                    done_q, done_d;
   logic                    cfg_err_q, cfg_err_d;
   logic                    busy_q, busy_d;
   logic [2:0]              ch_q, ch_d;
   logic [15:0]             j_q, j_d;
   logic [15:0]             t_q, t_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic [VALID_ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   status_word;
   logic [CHANNELS-1:0]     mask_sh;
   logic [2:0]              first_ch, next_ch;
   logic                    next_ok;
   logic signed [P-1:0]     x_elem, w_elem;
   logic                    mac_en, mac_clr;
   logic signed [ACC_W-1:0] acc;
   int                      wa, ra, ke, xe;

   // Element 0 lives in the most-significant P bits of a word.
   function automatic logic signed [P-1:0] elem_of(input logic [DATA_WIDTH-1:0] w,
                                                   input int pos);
      logic [DATA_WIDTH-1:0] sh;
      sh = w << (pos * P);
      return sh[DATA_WIDTH-1 -: P];
   endfunction

   // Sign-extend the sum to a bus word, optionally clamping negatives to zero.
   function automatic logic [DATA_WIDTH-1:0] wb_value(input logic signed [ACC_W-1:0] a);
      logic [DATA_WIDTH-1:0] ext;
      ext = {{(DATA_WIDTH-ACC_W){a[ACC_W-1]}}, a};
      if (RELU_EN && ext[DATA_WIDTH-1]) ext = '0;
      return ext;
   endfunction

   assign wr_addr = bus.i_write_addr;
   assign rd_addr = bus.i_read_addr;

   // Lowest enabled channel, and lowest enabled channel above the current one.
   always_comb begin
      first_ch = '0;
      next_ch  = '0;
      next_ok  = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         mask_sh = mask_q >> i;
         if (mask_sh[0]) begin
            first_ch = 3'(i);
            if (i > int'(ch_q)) begin
               next_ch = 3'(i);
               next_ok = 1'b1;
            end
         end
      end
   end

   // Operand fetch for tap t of output j on channel ch.
   always_comb begin
      ke     = int'(t_q);
      xe     = int'(j_q) + int'(t_q);
      w_elem = elem_of(kern_q[KIW'(int'(ch_q) * KW + ke / EPW)], ke % EPW);
      x_elem = elem_of(inp_q[IIW'(int'(ch_q) * IW + xe / EPW)], xe % EPW);
   end

   // Read decode sees only current register contents, so a same-cycle write
   // to the read address returns the old value.
   always_comb begin
      status_word              = '0;
      status_word[ST_DONE]     = done_q;
      status_word[ST_BUSY]     = busy_q;
      status_word[ST_CFG_ERR]  = cfg_err_q;
      status_word[ST_RELU]     = RELU_EN;
      ra      = int'(rd_addr);
      rd_word = '0;
      if (ra >= KBASE && ra < KBASE + NK)      rd_word = kern_q[KIW'(ra - KBASE)];
      else if (ra >= IBASE && ra < IBASE + NI) rd_word = inp_q[IIW'(ra - IBASE)];
      else if (ra >= OBASE && ra < OBASE + NO) rd_word = out_q[OIW'(ra - OBASE)];
      else if (ra == CFG_ADDR)                 rd_word = DATA_WIDTH'(cfg_q);
      else if (ra == MASK_ADDR)                rd_word = DATA_WIDTH'(mask_q);
      else if (ra == STATUS_ADDR)              rd_word = status_word;
   end

   always_comb begin
      state_d   = state_q;
      kern_d    = kern_q;
      inp_d     = inp_q;
      out_d     = out_q;
      cfg_d     = cfg_q;
      mask_d    = mask_q;
      done_d    = done_q;
      cfg_err_d = cfg_err_q;
      ch_d      = ch_q;
      j_d       = j_q;
      t_d       = t_q;
      mac_en    = 1'b0;
      mac_clr   = 1'b0;
      rdata_d   = bus.i_re ? rd_word : rdata_q;
      wa        = int'(wr_addr);

      // Host writes land only while idle; output and STATUS are not writable.
      if (bus.i_we && state_q == IDLE) begin
         if (wa >= KBASE && wa < KBASE + NK)      kern_d[KIW'(wa - KBASE)] = bus.i_data;
         else if (wa >= IBASE && wa < IBASE + NI) inp_d[IIW'(wa - IBASE)]  = bus.i_data;
         else if (wa == CFG_ADDR)                 cfg_d  = bus.i_data[15:0];
         else if (wa == MASK_ADDR)                mask_d = bus.i_data[CHANNELS-1:0];
         else if (wa == START_ADDR && bus.i_data[0]) begin
            state_d   = CHECK;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
         end
      end

      case (state_q)
         CHECK: begin
            if (cfg_q < K16 || cfg_q > MAXN16 || mask_q == '0) begin
               cfg_err_d = 1'b1;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               ch_d    = first_ch;
               j_d     = '0;
               t_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            mac_en  = 1'b1;
            mac_clr = (t_q == '0);
            if (t_q == K16 - 16'd1) begin
               t_d     = '0;
               state_d = WB;
            end else begin
               t_d = t_q + 16'd1;
            end
         end
         WB: begin
            out_d[OIW'(int'(ch_q) * MAX_INPUT_LEN + int'(j_q))] = wb_value(acc);
            // j == N-K is the last valid output position of this channel.
            if (j_q == cfg_q - K16) begin
               j_d = '0;
               if (next_ok) begin
                  ch_d    = next_ch;
                  state_d = MAC;
               end else begin
                  state_d = DONE;
               end
            end else begin
               j_d     = j_q + 16'd1;
               state_d = MAC;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         kern_q    <= '{default: '0};
         inp_q     <= '{default: '0};
         out_q     <= '{default: '0};
         cfg_q     <= '0;
         mask_q    <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         busy_q    <= 1'b0;
         ch_q      <= '0;
         j_q       <= '0;
         t_q       <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         kern_q    <= kern_d;
         inp_q     <= inp_d;
         out_q     <= out_d;
         cfg_q     <= cfg_d;
         mask_q    <= mask_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         busy_q    <= busy_d;
         ch_q      <= ch_d;
         j_q       <= j_d;
         t_q       <= t_d;
         rdata_q   <= rdata_d;
      end
   end

   conv_mac_lane #(
      .P         (P),
      .ACC_WIDTH (ACC_W)
   ) u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (mac_en),
      .i_clr (mac_clr),
      .i_a   (x_elem),
      .i_b   (w_elem),
      .o_acc (acc)
   );

   assign bus.o_data = rdata_q;
   assign bus.o_busy = busy_q;
   assign bus.o_done = done_q;

endmodule

// File: doc/conv_mc_mmio_engine.md
Name: conv_mc_mmio_engine

Overview:
Memory-mapped multi-channel 1-D convolution engine. It is the parametrised successor of the single-channel convolution memory interface. A host writes packed signed kernels, packed inputs and configuration through a word-addressed write port, then pulses START. The block runs one MAC per cycle across all enabled channels and exposes per-element results and status through a registered read port.

Parameters:
PRECISION_WIDTH, 4, signed element width P; must divide DATA_WIDTH.
DATA_WIDTH, 32, bus word width; elements per word EPW = DATA_WIDTH/P.
VALID_ADDR_WIDTH, 14, word-address width.
KERNEL_LEN, 9, taps K per channel; KW = ceil(K/EPW) kernel words per channel.
MAX_INPUT_LEN, 64, max input elements per channel; IW = MAX_INPUT_LEN/EPW.
CHANNELS, 2, number of independent channels (1..8).

Ports:
i_clk  in  1  clock.
i_rst  in  1  asynchronous, active-high reset.
i_we  in  1  write enable.
i_re  in  1  read enable.
i_write_addr  in  VALID_ADDR_WIDTH  write word address.
i_read_addr  in  VALID_ADDR_WIDTH  read word address.
i_data  in  DATA_WIDTH  write data.
o_data  out  DATA_WIDTH  registered read data.
o_busy  out  1  computation in progress.
o_done  out  1  sticky completion flag; mirrors STATUS bit0.

Behaviour:
- One clock domain: i_clk. Reset is asynchronous, active-high (i_rst). Reset clears the FSM to IDLE, all kernel, input and output storage, CFG, CH_MASK, STATUS, o_data, o_busy and o_done to 0.
- Memory map (word addresses):
  - Kernel ch c at 0x0000 + c*KW.
  - Input ch c at 0x0400 + c*IW.
  - Output ch c, element j at 0x1000 + c*MAX_INPUT_LEN + j. One result per word, sign-extended.
  - 0x3FFC CFG: [15:0] is the input length N.
  - 0x3FFD CH_MASK: [CHANNELS-1:0] enables channels.
  - 0x3FFE START: a write with bit0=1 starts a run.
  - 0x3FFF STATUS, read-only: bit0 done, bit1 busy, bit2 cfg_err.
- Packing: element 0 sits in the most-significant P bits of a word. Elements are two's complement.
- Writes: take effect at the clock edge where i_we=1. While busy, writes to kernel, input, CFG, CH_MASK and START are ignored. Writes to the output region, to STATUS or to unmapped addresses are always ignored.
- Reads: when i_re=1 at edge e, o_data holds the addressed word after edge e (1-cycle latency). When i_re=0, o_data holds its value. Unmapped addresses return 0.
- Read/write collision: i_we and i_re may be active together. A read of an address being written in the same cycle returns the old value.
- FSM states:
  - IDLE → CHECK on an accepted START. Accepting START clears done and cfg_err.
  - CHECK: if N<K, N>MAX_INPUT_LEN or CH_MASK==0, set cfg_err=1 and done=1, go to IDLE, and leave outputs untouched. Otherwise go to MAC with c = the lowest enabled channel and j=0.
  - MAC: K cycles. Each cycle does acc += x[c][j+t]*w[c][t], t=0..K-1. acc is cleared at entry.
  - WB: 1 cycle. Writes acc, sign-extended to DATA_WIDTH, to output[c][j]. Then j++. If j > N-K, move to the next enabled channel. If none remain, go to DONE.
  - DONE: 1 cycle. Sets done=1 and returns to IDLE.
- Accumulator width is 2P + clog2(K) bits. Overflow cannot occur.
- o_busy=1 in every state except IDLE. Busy length = 1 + Cen*(N-K+1)*(K+1) + 1 cycles, where Cen is the number of enabled channels.
- START while busy is ignored.
- Output words beyond N-K, and words of disabled channels, keep their previous values.
- Reset asserted mid-run aborts immediately. All state returns to reset values.

Optional Feature:
CONV_RELU_EN.
- Defined: WB writes max(acc, 0); negative results are stored as 0.
- Undefined: the signed result is stored unchanged.
- STATUS bit3 reads 1 when the macro is compiled in, else 0.

Decomposition:
- Package conv_mc_pkg holds:
  - Address base constants (KBASE, IBASE, OBASE, CFG/MASK/START/STATUS addresses).
  - STATUS bit indices.
  - The FSM state enum {IDLE, CHECK, MAC, WB, DONE}.
  - EPW/KW/IW/ACC_WIDTH localparam helper functions.
- One sub-module, conv_mac_lane: signed P×P multiply with synchronous clear-and-accumulate, parametrised by P and ACC_WIDTH.

Test Plan:
1. Reset: read 0x3FFF and 0x1000 → 0x00000000; o_busy=0, o_done=0.
2. Single channel, all ones:
   - Stimulus: kernel ch0 = 0x11111111 and 0x10000000. Input ch0 = two words of 0x11111111, N=16. CH_MASK=1, START.
   - Response: o_busy high for 82 cycles, then done=1. Reads 0x1000–0x1007 each return 0x00000009.
3. Signed path:
   - Stimulus: all kernel taps 0x7, all inputs 0xF (-1), N=9.
   - Response: 0x1000 = 0xFFFFFFC1 (-63). With CONV_RELU_EN compiled in → 0x00000000.
4. Config error:
   - Stimulus: N=5, START.
   - Response: STATUS=0x5 (0xD with CONV_RELU_EN compiled in) two cycles later. Output region is unchanged.
5. Two channels:
   - Stimulus: CH_MASK=0b11. ch0 as in test 2. ch1 inputs all 2 (words at 0x0408–0x0409). Mid-run, write the input region and START again.
   - Response: ch1 results at 0x1040–0x1047 = 0x00000012. Both busy-time writes are ignored. Total busy is 162 cycles.
6. Reset mid-run: assert i_rst 20 cycles after START → STATUS=0 and 0x1000 reads 0.
